// File: rtl/cc_frame_sequencer_pkg.sv
// Shared definitions for the connected-components frame sequencer:
// bus widths used by the labeler interface and the sequencer state encoding.
package cc_frame_sequencer_pkg;

  // Label / object-table index width.
  localparam int WORD_SIZE = 10;
  // Coordinate width; holds every column/row index plus the HEIGHT pad row.
  localparam int LOC_SIZE  = 10;
  // Object area width; large enough for a full-frame blob.
  localparam int OBJ_WIDTH = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    ISSUE = 3'd3,
    EVAL  = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/cc_frame_sequencer_raster.sv
// cc_raster_counter: raster x/y generator shared by the scan and drain phases.
// x advances on 'advance' and wraps at WIDTH-1; y increments on a wrap only
// while 'row_en' is high, so the drain phase can park y on the pad row.
module cc_raster_counter
  import cc_frame_sequencer_pkg::*;
#(
  parameter int WIDTH = 640
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                advance,
  input  logic                row_en,
  output logic [LOC_SIZE-1:0] x,
  output logic [LOC_SIZE-1:0] y
);

  localparam logic [LOC_SIZE-1:0] X_LAST = LOC_SIZE'(WIDTH - 1);

  // Column/row registers: equality compare at the row end, never overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        if (row_en) begin
          y <= y + LOC_SIZE'(1);
        end else begin
          y <= y;
        end
      end else begin
        x <= x + LOC_SIZE'(1);
      end
    end else begin
      x <= x;
      y <= y;
    end
  end

endmodule

// File: rtl/cc_frame_sequencer.sv
// cc_frame_sequencer: frame-level controller for the connected-components
// labeler. Streams a frame into the labeler, pads DRAIN_CYC cycles so the
// pipeline and merge stacks empty, then walks the object table and emits one
// centroid record per surviving object on a valid/ready port.
// Optional build macro CC_MIN_AREA_EN adds a min_area input; objects smaller
// than min_area are suppressed along with merged-away (zero-area) labels.
module cc_frame_sequencer
  import cc_frame_sequencer_pkg::*;
#(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int DRAIN_CYC = 260,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 en,
  output logic                 pad,
  output logic [LOC_SIZE-1:0]  x,
  output logic [LOC_SIZE-1:0]  y,
  input  logic [WORD_SIZE-1:0] num_labels,
  output logic [WORD_SIZE-1:0] obj_id,
  input  logic [OBJ_WIDTH-1:0] obj_area,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
`ifdef CC_MIN_AREA_EN
  input  logic [OBJ_WIDTH-1:0] min_area,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] res_id,
  output logic [LOC_SIZE-1:0]  res_x,
  output logic [LOC_SIZE-1:0]  res_y,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int RDW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LOC_SIZE-1:0] X_LAST  = LOC_SIZE'(WIDTH - 1);
  localparam logic [LOC_SIZE-1:0] Y_LAST  = LOC_SIZE'(HEIGHT - 1);
  localparam logic [LOC_SIZE-1:0] D_LAST  = LOC_SIZE'(DRAIN_CYC - 1);
  localparam logic [RDW-1:0]      RD_LAST = RDW'(RD_LAT);

  seq_state_e state, state_next;

  logic [WORD_SIZE-1:0] k;
  logic [WORD_SIZE-1:0] n_snap;
  logic [LOC_SIZE-1:0]  drain_cnt;
  logic [RDW-1:0]       rd_cnt;
  logic [OBJ_WIDTH-1:0] cap_area;
  logic [LOC_SIZE-1:0]  cap_x;
  logic [LOC_SIZE-1:0]  cap_y;

  logic clear_raster, adv_raster, row_en;
  logic capture, load_res, k_inc;
  logic pix_last, drain_last, rd_done, k_last, few_labels, skip;

  assign pix_last   = pix_valid && (x == X_LAST) && (y == Y_LAST);
  assign drain_last = (drain_cnt == D_LAST);
  assign rd_done    = (rd_cnt == RD_LAST);
  assign k_last     = (k == (n_snap - WORD_SIZE'(1)));
  assign few_labels = (n_snap <= WORD_SIZE'(1));

`ifdef CC_MIN_AREA_EN
  assign skip = (cap_area == OBJ_WIDTH'(0)) || (cap_area < min_area);
`else
  assign skip = (cap_area == OBJ_WIDTH'(0));
`endif

  cc_raster_counter #(
    .WIDTH (WIDTH)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_raster),
    .advance (adv_raster),
    .row_en  (row_en),
    .x       (x),
    .y       (y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle datapath strobes.
  always_comb begin
    state_next   = state;
    clear_raster = 1'b0;
    adv_raster   = 1'b0;
    row_en       = 1'b0;
    capture      = 1'b0;
    load_res     = 1'b0;
    k_inc        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_raster = 1'b1;
          state_next   = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        adv_raster = pix_valid;
        row_en     = 1'b1;
        if (pix_last) begin
          state_next = DRAIN;
        end else begin
          state_next = SCAN;
        end
      end
      DRAIN: begin
        // y stays on the pad row while x keeps sweeping.
        adv_raster = 1'b1;
        if (drain_last) begin
          state_next = ISSUE;
        end else begin
          state_next = DRAIN;
        end
      end
      ISSUE: begin
        if (few_labels) begin
          state_next = DONE;
        end else if (rd_done) begin
          capture    = 1'b1;
          state_next = EVAL;
        end else begin
          state_next = ISSUE;
        end
      end
      EVAL: begin
        if (skip) begin
          if (k_last) begin
            state_next = DONE;
          end else begin
            k_inc      = 1'b1;
            state_next = ISSUE;
          end
        end else begin
          load_res   = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (res_ready) begin
          if (k_last) begin
            state_next = DONE;
          end else begin
            k_inc      = 1'b1;
            state_next = ISSUE;
          end
        end else begin
          state_next = EMIT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Phase counters, label snapshot, object index and record registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k         <= WORD_SIZE'(1);
      n_snap    <= '0;
      drain_cnt <= '0;
      rd_cnt    <= '0;
      cap_area  <= '0;
      cap_x     <= '0;
      cap_y     <= '0;
      res_id    <= '0;
      res_x     <= '0;
      res_y     <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + LOC_SIZE'(1) : LOC_SIZE'(0);
      rd_cnt    <= (state == ISSUE) ? rd_cnt + RDW'(1) : RDW'(0);
      // Label count is frozen on the first drain cycle.
      if ((state == DRAIN) && (drain_cnt == LOC_SIZE'(0))) begin
        n_snap <= num_labels;
      end else begin
        n_snap <= n_snap;
      end
      if (clear_raster) begin
        k <= WORD_SIZE'(1);
      end else if (k_inc) begin
        k <= k + WORD_SIZE'(1);
      end else begin
        k <= k;
      end
      if (capture) begin
        cap_area <= obj_area;
        cap_x    <= obj_x;
        cap_y    <= obj_y;
      end else begin
        cap_area <= cap_area;
        cap_x    <= cap_x;
        cap_y    <= cap_y;
      end
      if (load_res) begin
        res_id <= k;
        res_x  <= cap_x;
        res_y  <= cap_y;
      end else begin
        res_id <= res_id;
        res_x  <= res_x;
        res_y  <= res_y;
      end
    end
  end

  // Outputs decode the registered state; en also follows the live pixel handshake.
  assign pix_ready  = (state == SCAN);
  assign pad        = (state == DRAIN);
  assign en         = ((state == SCAN) && pix_valid) || (state == DRAIN);
  assign obj_id     = k;
  assign res_valid  = (state == EMIT);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_cc_frame_sequencer.sv
// Directed bench for cc_frame_sequencer on a 4x2 frame with a short drain.
module tb_cc_frame_sequencer;
  import cc_frame_sequencer_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DC = 6;

  logic                 clk = 1'b0;
  logic                 reset_n, start, pix_valid, res_ready;
  logic                 pix_ready, en, pad, res_valid, busy, frame_done;
  logic [LOC_SIZE-1:0]  x, y, obj_x, obj_y, res_x, res_y;
  logic [WORD_SIZE-1:0] num_labels, obj_id, res_id;
  logic [OBJ_WIDTH-1:0] obj_area;
`ifdef CC_MIN_AREA_EN
  logic [OBJ_WIDTH-1:0] min_area = '0;
`endif

  logic [OBJ_WIDTH-1:0] area_mem [16];
  logic [LOC_SIZE-1:0]  x_mem    [16];
  logic [LOC_SIZE-1:0]  y_mem    [16];

  int checks = 0;
  int errors = 0;

  cc_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .DRAIN_CYC(DC), .RD_LAT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .en(en), .pad(pad), .x(x), .y(y),
    .num_labels(num_labels), .obj_id(obj_id),
    .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
`ifdef CC_MIN_AREA_EN
    .min_area(min_area),
`endif
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_x(res_x), .res_y(res_y),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Object table model with one cycle of read latency.
  always @(posedge clk) begin
    obj_area <= area_mem[obj_id[3:0]];
    obj_x    <= x_mem[obj_id[3:0]];
    obj_y    <= y_mem[obj_id[3:0]];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; res_ready = 1'b0;
    num_labels = '0;
    for (int i = 0; i < 16; i++) begin
      area_mem[i] = '0; x_mem[i] = '0; y_mem[i] = '0;
    end
    area_mem[1] = OBJ_WIDTH'(5); x_mem[1] = LOC_SIZE'(10); y_mem[1] = LOC_SIZE'(11);
    area_mem[2] = OBJ_WIDTH'(0); x_mem[2] = LOC_SIZE'(20); y_mem[2] = LOC_SIZE'(22);
    area_mem[3] = OBJ_WIDTH'(3); x_mem[3] = LOC_SIZE'(30); y_mem[3] = LOC_SIZE'(33);

    // Reset state.
    tick(); tick();
    check("reset_ctl", {busy, en, pad, pix_ready, res_valid, frame_done}, 64'd0);
    check("reset_obj_id", obj_id, 64'd1);
    check("reset_xy", {x, y}, 64'd0);
    check("reset_res", {res_id, res_x, res_y}, 64'd0);

    // Frame 1: continuous pixels, four labels with areas {5,0,3}.
    reset_n = 1'b1; num_labels = WORD_SIZE'(4); pix_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("scan_f1", {en, pad, pix_ready, busy, x, y},
            {1'b1, 1'b0, 1'b1, 1'b1, LOC_SIZE'(i % W), LOC_SIZE'(i / W)});
      tick();
    end
    pix_valid = 1'b0;
    for (int d = 0; d < DC; d++) begin
      check("drain_f1", {en, pad, pix_ready, x, y},
            {1'b1, 1'b1, 1'b0, LOC_SIZE'(d % W), LOC_SIZE'(H)});
      tick();
    end
    check("issue_id1", {obj_id, en, res_valid}, {WORD_SIZE'(1), 1'b0, 1'b0});
    tick(); tick();
    check("eval_id1", {res_valid, busy}, 64'b01);
    tick();
    // Consumer stalls for five cycles; the record must hold.
    for (int i = 0; i < 5; i++) begin
      check("emit1_hold", {res_valid, res_id, res_x, res_y},
            {1'b1, WORD_SIZE'(1), LOC_SIZE'(10), LOC_SIZE'(11)});
      tick();
    end
    check("emit1_release", {res_valid, res_id, res_x, res_y},
          {1'b1, WORD_SIZE'(1), LOC_SIZE'(10), LOC_SIZE'(11)});
    res_ready = 1'b1;
    tick();
    check("issue_id2", {obj_id, res_valid}, {WORD_SIZE'(2), 1'b0});
    tick(); tick();
    check("eval_id2_skip", {obj_id, res_valid, busy}, {WORD_SIZE'(2), 1'b0, 1'b1});
    tick();
    check("issue_id3", {obj_id, res_valid}, {WORD_SIZE'(3), 1'b0});
    tick(); tick(); tick();
    check("emit3", {res_valid, res_id, res_x, res_y},
          {1'b1, WORD_SIZE'(3), LOC_SIZE'(30), LOC_SIZE'(33)});
    tick();
    check("done_f1", {frame_done, busy, res_valid}, 64'b110);
    tick();
    check("idle_f1", {frame_done, busy, res_valid}, 64'b000);

    // Frame 2: pix_valid toggles, start pulse mid-scan, single label.
    res_ready = 1'b0; num_labels = WORD_SIZE'(1); pix_valid = 1'b1; start = 1'b1;
    tick();
    for (int c = 0; c < 16; c++) begin
      pix_valid = (c % 2 == 1);
      start     = (c == 5);
      #1;
      check("scan_f2", {en, pix_ready, x, y},
            {1'(c % 2), 1'b1, LOC_SIZE'((c / 2) % W), LOC_SIZE'((c / 2) / W)});
      tick();
    end
    pix_valid = 1'b0; start = 1'b0;
    check("drain_f2", {pad, en, x, y}, {1'b1, 1'b1, LOC_SIZE'(0), LOC_SIZE'(H)});
    repeat (DC) tick();
    check("issue_f2", {obj_id, busy, frame_done, en}, {WORD_SIZE'(1), 1'b1, 1'b0, 1'b0});
    tick();
    check("done_f2", {frame_done, res_valid}, 64'b10);
    tick();
    check("idle_f2", {frame_done, busy}, 64'b00);

    // Frame 3: reset during drain aborts with no frame_done.
    num_labels = WORD_SIZE'(4); pix_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    pix_valid = 1'b0;
    check("drain_f3", {pad, busy}, 64'b11);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    check("abort_ctl", {busy, en, pad, frame_done, res_valid}, 64'd0);
    check("abort_obj_id", obj_id, 64'd1);
    check("abort_xy", {x, y}, 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort_quiet", {frame_done, busy, res_valid}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_frame_sequencer.md
Name: cc_frame_sequencer

Overview:
Frame-level controller for the connected-components labeler. Drives the labeler enable and raster coordinates while pixels stream in, then drains the pipeline and flushes the merge stacks. After that it walks the object table by obj_id and emits one centroid record per surviving object on a valid/ready output. It sits between the pixel source, the labeler, and the downstream object consumer.

Parameters:
WIDTH, 640, pixels per row.
HEIGHT, 480, rows per frame.
DRAIN_CYC, 260, padded cycles after the last pixel. Must be at least the merge-stack depth plus the labeler pipeline depth.
RD_LAT, 1, cycles from obj_id change to valid obj_area/obj_x/obj_y.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
start  in  1  begin a frame; sampled only in IDLE
pix_valid  in  1  upstream pixel available
pix_ready  out  1  sequencer accepts a pixel
en  out  1  labeler enable
pad  out  1  upstream forces p=0 while high
x  out  `LOC_SIZE  column to labeler
y  out  `LOC_SIZE  row to labeler
num_labels  in  `WORD_SIZE  labeler label count
obj_id  out  `WORD_SIZE  object-table read index
obj_area  in  `OBJ_WIDTH  area of obj_id
obj_x  in  `LOC_SIZE  centroid x of obj_id
obj_y  in  `LOC_SIZE  centroid y of obj_id
res_valid  out  1  record available
res_ready  in  1  consumer accepts record
res_id  out  `WORD_SIZE  record label
res_x  out  `LOC_SIZE  record centroid x
res_y  out  `LOC_SIZE  record centroid y
busy  out  1  not IDLE
frame_done  out  1  one-cycle pulse at end of readout

Behaviour:
- Reset (synchronous, reset_n low): state IDLE. All outputs 0 except obj_id=1. Counters cleared. Reset mid-frame or mid-readout aborts immediately; no frame_done.
- IDLE: start=1 -> SCAN with x=y=0. Start in any other state is ignored.
- SCAN:
  - pix_ready=1 and en=pix_valid.
  - On an accepted pixel, x increments.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - Accepting pixel (WIDTH-1, HEIGHT-1) -> DRAIN next cycle.
  - No accepted pixel: x, y and en hold, with en=0.
- DRAIN:
  - pix_ready=0, en=1, pad=1, y=HEIGHT (toggles y[0] so the final row's merges pop), x counts 0.. and wraps per WIDTH.
  - Lasts exactly DRAIN_CYC cycles.
  - On entry, num_labels is snapshotted into n_snap.
- ISSUE:
  - obj_id=k, where k starts at 1; en=0.
  - If n_snap<=1, go straight to DONE.
  - Otherwise wait RD_LAT cycles, then capture area/x/y -> EVAL.
- EVAL:
  - area==0 means the label was merged away: skip.
  - Otherwise load res_* and go to EMIT.
- EMIT:
  - res_valid=1; res_* stable until res_ready is sampled high.
  - res_valid and res_ready both high completes the transfer.
- Advance (after a skip or a completed transfer):
  - k==n_snap-1 -> DONE.
  - Otherwise k+1 -> ISSUE.
- DONE: frame_done=1 for one cycle -> IDLE.
- res_ready high outside EMIT has no effect.
- Counters are sized to LOC_SIZE. The WIDTH/HEIGHT compare uses equality, never overflow.
- Latency: the first record can appear no earlier than RD_LAT+2 cycles after DRAIN ends.

Optional Feature:
CC_MIN_AREA_EN
- Defined: adds input port min_area (`OBJ_WIDTH). EVAL also skips an object when area<min_area, so noise blobs are suppressed. min_area is sampled in EVAL.
- Undefined: the port is absent and only area==0 is skipped.

Decomposition:
- Shared package/header (global.vh): WORD_SIZE, LOC_SIZE, OBJ_WIDTH, and the state encoding localparams (IDLE, SCAN, DRAIN, ISSUE, EVAL, EMIT, DONE).
- One sub-module, cc_raster_counter: x/y generator with advance input, wrap at WIDTH, and row increment. Shared between SCAN and DRAIN.

Test Plan:
- WIDTH=4, HEIGHT=2, pix_valid always 1, start pulse -> en high for exactly 8 cycles with (x,y) sequence (0,0)..(3,1), then DRAIN_CYC cycles with pad=1 and y=2.
- pix_valid toggling 1,0,1,0 -> x advances only on valid cycles; frame takes 16 SCAN cycles.
- num_labels=4 with areas {5,0,3} for ids {1,2,3} -> exactly two records, res_id 1 then 3, then frame_done pulse.
- res_ready held 0 for 5 cycles during EMIT -> res_valid stays 1 and res_* unchanged; one transfer on release.
- num_labels=1 -> no res_valid; frame_done one cycle after the ISSUE entry.
- reset_n low during DRAIN -> next cycle busy=0, en=0, no frame_done.
- With CC_MIN_AREA_EN and min_area=4, areas {5,0,3} -> only id 1 is emitted.
